// File: rtl/dportrom_fetch_if.sv
// Bundle between dportrom_fetch and its environment: request/status, both
// ROM address/data ports, and the 64-bit valid/ready output stream.
interface dportrom_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 64
);
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] q_a;
    logic [DW-1:0] q_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output start, base, len, q_a, q_b, out_ready,
        input  busy, done, addr_a, addr_b, out_valid, out_data, out_last
    );

    modport slave (
        input  start, base, len, q_a, q_b, out_ready,
        output busy, done, addr_a, addr_b, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dportrom_fetch.sv
// Dual-port ROM read sequencer: issues addr/addr+1 pairs, hides the ROM's
// one-cycle read latency and streams words in order through a credit-checked FIFO.
module dportrom_fetch #(
    parameter int AW    = 8,
    parameter int DW    = 64,
    parameter int DEPTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    dportrom_fetch_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_TWO = {{(AW-2){1'b0}}, 2'b10};
    localparam logic [AW:0]   LEN_TWO  = {{(AW-1){1'b0}}, 2'b10};
    localparam logic [SW-1:0] CRED_TWO = {{(SW-2){1'b0}}, 2'b10};
    localparam logic [SW-1:0] DEPTH_W  = SW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    logic          busy_r;
    logic          done_r;
    logic [AW-1:0] next_addr_r;
    logic [AW:0]   remaining_r;
    logic [AW-1:0] addr_a_r;
    logic [AW-1:0] addr_b_r;

    logic p1_valid_r, p1_keep_b_r, p1_last_r;
    logic p2_valid_r, p2_keep_b_r, p2_last_r;

    logic [DW:0]   mem_r [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          out_last_r;

    logic          start_ok_s;
    logic          issue_s;
    logic          keep_b_s;
    logic          last_pair_s;
    logic [AW:0]   take_s;
    logic [1:0]    p1_w_s;
    logic [1:0]    p2_w_s;
    logic [2:0]    inflight_s;
    logic [SW-1:0] credit_sum_s;
    logic          rd_s;
    logic          wr_a_s;
    logic          wr_b_s;
    logic          last_a_s;
    logic          last_b_s;
    logic [PW-1:0] wptr_b_s;
    logic [PW-1:0] rptr_next_s;
    logic [CW-1:0] count_next_s;
    logic [DW:0]   head_next_s;

    // Issue decision: a pair goes out only if FIFO plus in-flight words leave room for two more.
    always_comb begin
        start_ok_s   = (state_r == ST_IDLE) && bus.start && !done_r;
        keep_b_s     = (remaining_r >= LEN_TWO);
        last_pair_s  = (remaining_r <= LEN_TWO);
        take_s       = {{(AW-1){1'b0}}, keep_b_s, ~keep_b_s};
        p1_w_s       = {p1_valid_r & p1_keep_b_r, p1_valid_r & ~p1_keep_b_r};
        p2_w_s       = {p2_valid_r & p2_keep_b_r, p2_valid_r & ~p2_keep_b_r};
        inflight_s   = {1'b0, p1_w_s} + {1'b0, p2_w_s};
        credit_sum_s = SW'(count_r) + SW'(inflight_s) + CRED_TWO;
        issue_s      = (state_r == ST_FETCH) && (credit_sum_s <= DEPTH_W);
    end

    // FIFO bookkeeping: two writes (A then B) and one read per cycle, plus next head word.
    always_comb begin
        rd_s         = out_valid_r & bus.out_ready;
        wr_a_s       = p2_valid_r;
        wr_b_s       = p2_valid_r & p2_keep_b_r;
        last_a_s     = p2_last_r & ~p2_keep_b_r;
        last_b_s     = p2_last_r & p2_keep_b_r;
        wptr_b_s     = wptr_r + PW'(1'b1);
        rptr_next_s  = rptr_r + PW'(rd_s);
        count_next_s = count_r + CW'(p2_w_s) - CW'(rd_s);
        if (wr_a_s && (wptr_r == rptr_next_s)) begin
            head_next_s = {last_a_s, bus.q_a};
        end else if (wr_b_s && (wptr_b_s == rptr_next_s)) begin
            head_next_s = {last_b_s, bus.q_b};
        end else begin
            head_next_s = mem_r[rptr_next_s];
        end
    end

    // Control FSM: start capture, pair issue onto the ROM ports, completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            next_addr_r <= '0;
            remaining_r <= '0;
            addr_a_r    <= '0;
            addr_b_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        next_addr_r <= bus.base;
                        remaining_r <= bus.len;
                        if (bus.len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_s) begin
                        addr_a_r    <= next_addr_r;
                        addr_b_r    <= next_addr_r + ADDR_ONE;
                        next_addr_r <= next_addr_r + ADDR_TWO;
                        remaining_r <= remaining_r - take_s;
                        if (last_pair_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_s && out_last_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage tag pipe aligned with address register plus ROM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_r  <= 1'b0;
            p1_keep_b_r <= 1'b0;
            p1_last_r   <= 1'b0;
            p2_valid_r  <= 1'b0;
            p2_keep_b_r <= 1'b0;
            p2_last_r   <= 1'b0;
        end else begin
            p1_valid_r  <= issue_s;
            p1_keep_b_r <= keep_b_s;
            p1_last_r   <= last_pair_s;
            p2_valid_r  <= p1_valid_r;
            p2_keep_b_r <= p1_keep_b_r;
            p2_last_r   <= p1_last_r;
        end
    end

    // Output FIFO storage, pointers and registered show-ahead head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wptr_r      <= '0;
            rptr_r      <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else begin
            if (wr_a_s) begin
                mem_r[wptr_r] <= {last_a_s, bus.q_a};
            end
            if (wr_b_s) begin
                mem_r[wptr_b_s] <= {last_b_s, bus.q_b};
            end
            wptr_r      <= wptr_r + PW'(p2_w_s);
            rptr_r      <= rptr_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != '0);
            out_data_r  <= head_next_s[DW-1:0];
            out_last_r  <= head_next_s[DW];
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.addr_a    = addr_a_r;
    assign bus.addr_b    = addr_b_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_dportrom_fetch.sv
// Scoreboard bench for dportrom_fetch: ROM image word i = i, expected beats
// queued at start, a forked monitor pops and compares each handshake.
module tb_dportrom_fetch;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   beats;
    int   max_occ;
    logic [64:0] exp_q[$];

    dportrom_fetch_if #(.AW(8), .DW(64)) bus ();

    dportrom_fetch #(.AW(8), .DW(64), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model with one-cycle registered read
    always @(posedge clk) begin
        bus.q_a <= {56'h0, bus.addr_a};
        bus.q_b <= {56'h0, bus.addr_b};
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b, input int l);
        logic [7:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + 8'(i);
            exp_q.push_back({(i == l - 1), 56'h0, a});
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] l);
        bus.start = 1'b1;
        bus.base  = b;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int k);
        k = 0;
        while (!bus.done && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_done_seen"}, 64'(bus.done), 64'd1);
    endtask

    task automatic monitor();
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && 32'(dut.count_r) > max_occ) max_occ = 32'(dut.count_r);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                checks++;
                beats++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got last=%b data=%h, required no beat",
                             bus.out_last, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_last, bus.out_data} !== e) begin
                        errors++;
                        $display("FAIL beat: got last=%b data=%h, required last=%b data=%h",
                                 bus.out_last, bus.out_data, e[64], e[63:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        int k;
        int b0;
        logic saw_valid;
        checks = 0; errors = 0; beats = 0; max_occ = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base = 8'h00; bus.len = 9'd0; bus.out_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_last", 64'(bus.out_last), 64'd0);
        chk("rst_addr_a", 64'(bus.addr_a), 64'd0);
        chk("rst_addr_b", 64'(bus.addr_b), 64'd0);
        chk("rst_data", bus.out_data, 64'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Basic: 10..13, first word 3 cycles after start, done at N+3
        push_exp(8'h10, 4);
        do_start(8'h10, 9'd4);
        chk("basic_busy", 64'(bus.busy), 64'd1);
        tick(); tick();
        chk("basic_valid_edge2", 64'(bus.out_valid), 64'd0);
        tick();
        chk("basic_valid_edge3", 64'(bus.out_valid), 64'd1);
        wait_done("basic", 50, k);
        chk("basic_done_cycle", 64'(k + 3), 64'd7);
        chk("basic_busy_at_done", 64'(bus.busy), 64'd0);
        chk("basic_addr_a", 64'(bus.addr_a), 64'h12);
        chk("basic_addr_b", 64'(bus.addr_b), 64'h13);
        tick();
        chk("basic_done_pulse", 64'(bus.done), 64'd0);
        chk("basic_drained", 64'(exp_q.size()), 64'd0);

        // Odd length: 20,21,22, word 23 dropped
        push_exp(8'h20, 3);
        do_start(8'h20, 9'd3);
        wait_done("odd", 50, k);
        chk("odd_addr_a", 64'(bus.addr_a), 64'h22);
        chk("odd_addr_b", 64'(bus.addr_b), 64'h23);
        tick();
        chk("odd_drained", 64'(exp_q.size()), 64'd0);

        // Wrap: FE,FF,00,01
        push_exp(8'hFE, 4);
        do_start(8'hFE, 9'd4);
        wait_done("wrap4", 50, k);
        chk("wrap4_addr_b", 64'(bus.addr_b), 64'h01);
        tick();
        chk("wrap4_drained", 64'(exp_q.size()), 64'd0);

        // Full ROM sweep: exactly 256 beats
        b0 = beats;
        push_exp(8'h00, 256);
        do_start(8'h00, 9'd256);
        wait_done("full", 400, k);
        chk("full_done_cycle", 64'(k), 64'd259);
        chk("full_beats", 64'(beats - b0), 64'd256);
        tick();
        chk("full_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: ready low for cycles 2..11, then alternating
        max_occ = 0;
        push_exp(8'h80, 16);
        do_start(8'h80, 9'd16);
        k = 0;
        while (!bus.done && k < 300) begin
            tick();
            k++;
            if (k <= 10) bus.out_ready = 1'b0;
            else if (k == 11) bus.out_ready = 1'b1;
            else bus.out_ready = ~bus.out_ready;
        end
        chk("bp_done_seen", 64'(bus.done), 64'd1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_max_occupancy_ok", 64'(max_occ <= 8), 64'd1);
        chk("bp_fifo_filled", 64'(max_occ >= 6), 64'd1);
        bus.out_ready = 1'b1;
        tick();

        // Degenerate: len=0 gives done next cycle and no data
        do_start(8'h05, 9'd0);
        chk("len0_done", 64'(bus.done), 64'd1);
        chk("len0_busy", 64'(bus.busy), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_valid = saw_valid | bus.out_valid;
        end
        chk("len0_no_valid", 64'(saw_valid), 64'd0);

        // Start while busy, and start in the done cycle, both ignored
        push_exp(8'h50, 4);
        do_start(8'h50, 9'd4);
        tick();
        do_start(8'h60, 9'd2);
        wait_done("ignore", 50, k);
        do_start(8'h70, 9'd1);
        chk("ignore_busy_after_done_start", 64'(bus.busy), 64'd0);
        repeat (6) tick();
        chk("ignore_drained", 64'(exp_q.size()), 64'd0);
        chk("ignore_idle_valid", 64'(bus.out_valid), 64'd0);

        // Reset after 5 words of a 16-word transfer
        b0 = beats;
        push_exp(8'h30, 16);
        do_start(8'h30, 9'd16);
        k = 0;
        while (beats < b0 + 5 && k < 40) begin
            tick();
            k++;
        end
        chk("rst5_reached", 64'(beats - b0), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_last", 64'(bus.out_last), 64'd0);
        chk("mid_rst_addr_a", 64'(bus.addr_a), 64'd0);
        chk("mid_rst_data", bus.out_data, 64'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        push_exp(8'h40, 2);
        do_start(8'h40, 9'd2);
        wait_done("post_rst", 50, k);
        tick();
        chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
